// File: rtl/n64_vdata_gen_pkg.sv
// Shared constants and types for the synthetic N64 video-bus transmitter.
// The sync-nibble bit indices and pattern encodings are also used by the extractor.
package n64_vdata_gen_pkg;

  localparam int unsigned NIB_VSYNC = 3;
  localparam int unsigned NIB_CLAMP = 2;
  localparam int unsigned NIB_HSYNC = 1;
  localparam int unsigned NIB_CSYNC = 0;

  localparam int unsigned H_TOTAL_NTSC_C = 773;
  localparam int unsigned H_TOTAL_PAL_C  = 794;
  // Progressive and even-field length; an interlaced odd field is one line shorter.
  localparam int unsigned V_TOTAL_NTSC_C = 263;
  localparam int unsigned V_TOTAL_PAL_C  = 313;
  localparam int unsigned V_ACT_LEN_NTSC_C = 240;
  localparam int unsigned V_ACT_LEN_PAL_C  = 288;

  localparam int unsigned H_W = 10;
  localparam int unsigned V_W = 9;

  localparam logic [6:0] LVL_FULL = 7'h7F;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  typedef enum logic {
    FIELD_EVEN = 1'b0,
    FIELD_ODD  = 1'b1
  } field_e;

  typedef struct packed {
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
  } rgb_t;

endpackage

// File: rtl/n64_vgen_pattern.sv
// Test-pattern generator: active-area offsets and pattern select to RGB,
// registered on the sync slot so the colour is stable for the R/G/B slots.
module n64_vgen_pattern
  import n64_vdata_gen_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           active_i,
  input  pattern_e       pattern_i,
  input  logic [H_W-1:0] ha_i,
  input  logic [V_W-1:0] va_i,
  output rgb_t           rgb_o
);

  rgb_t       rgb_d;
  rgb_t       rgb_q;
  logic [2:0] bar_idx;

  always_comb begin
    rgb_d   = '0;
    bar_idx = 3'(ha_i / H_W'(80));
    if (active_i) begin
      case (pattern_i)
        PAT_BARS: begin
          rgb_d.r = {7{bar_idx[2]}};
          rgb_d.g = {7{bar_idx[1]}};
          rgb_d.b = {7{bar_idx[0]}};
        end
        PAT_GRID: begin
          if (ha_i[4:0] == '0 || va_i[3:0] == '0) begin
            rgb_d.r = LVL_FULL;
            rgb_d.g = LVL_FULL;
            rgb_d.b = LVL_FULL;
          end
        end
        PAT_RAMP: begin
          rgb_d.r = ha_i[6:0];
          rgb_d.g = ha_i[6:0];
          rgb_d.b = ha_i[6:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else if (load_i) begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/n64_vdata_gen.sv
// Synthetic N64 video-bus transmitter: 4-phase nDSYNC/D stream (sync nibble, R, G, B)
// for 240p/288p/480i/576i, all logic on the falling edge of nCLK.
module n64_vdata_gen
  import n64_vdata_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL_NTSC = H_TOTAL_NTSC_C,
  parameter int unsigned H_TOTAL_PAL  = H_TOTAL_PAL_C,
  parameter int unsigned H_SYNC_LEN   = 57,
  parameter int unsigned CLAMP_START  = 64,
  parameter int unsigned CLAMP_LEN    = 32,
  parameter int unsigned V_SYNC_LINES = 3,
  parameter int unsigned H_ACT_START  = 128,
  parameter int unsigned H_ACT_LEN    = 640,
  parameter int unsigned V_ACT_START  = 20
) (
  input  logic       nCLK,
  input  logic       RST,
  input  logic       vmode_i,
  input  logic       n64_480i_i,
  input  logic [1:0] pattern_i,
  output logic       nDSYNC,
  output logic [6:0] D_o,
  output logic       frame_start_o
);

  localparam logic [H_W-1:0] HTOT_N     = H_W'(H_TOTAL_NTSC);
  localparam logic [H_W-1:0] HTOT_P     = H_W'(H_TOTAL_PAL);
  localparam logic [H_W-1:0] HSYNC_END  = H_W'(H_SYNC_LEN);
  localparam logic [H_W-1:0] CLAMP_BEG  = H_W'(CLAMP_START);
  localparam logic [H_W-1:0] CLAMP_END  = H_W'(CLAMP_START + CLAMP_LEN);
  localparam logic [H_W-1:0] HACT_BEG   = H_W'(H_ACT_START);
  localparam logic [H_W-1:0] HACT_END   = H_W'(H_ACT_START + H_ACT_LEN);
  localparam logic [V_W-1:0] VSYNC_END  = V_W'(V_SYNC_LINES);
  localparam logic [V_W-1:0] VACT_BEG   = V_W'(V_ACT_START);
  localparam logic [V_W-1:0] VACT_END_N = V_W'(V_ACT_START + V_ACT_LEN_NTSC_C);
  localparam logic [V_W-1:0] VACT_END_P = V_W'(V_ACT_START + V_ACT_LEN_PAL_C);
  localparam logic [V_W-1:0] VTOT_N     = V_W'(V_TOTAL_NTSC_C);
  localparam logic [V_W-1:0] VTOT_P     = V_W'(V_TOTAL_PAL_C);

  phase_e         ph_q, ph_d;
  logic [H_W-1:0] h_q, h_d, h_tot, h_half, ha;
  logic [V_W-1:0] v_q, v_d, v_len, vact_end, va;
  field_e         field_q, field_d;
  logic           vmode_q, i480_q;
  pattern_e       pat_q;
  logic           line_start, frame_bound, pix_end, line_end, field_end;
  logic           nvs, nhs, ncl, ncs, active;
  rgb_t           rgb;
  logic           nds_d, nds_q, fs_d, fs_q;
  logic [6:0]     d_d, d_q;

  assign h_tot  = vmode_q ? HTOT_P : HTOT_N;
  assign h_half = h_tot >> 1;

  always_comb begin
    v_len = vmode_q ? VTOT_P : VTOT_N;
    if (i480_q && field_q == FIELD_ODD) begin
      v_len = v_len - V_W'(1);
    end
  end

  assign line_start  = (ph_q == PH_SYNC) && (h_q == '0);
  assign frame_bound = line_start && (v_q == '0) && (field_q == FIELD_ODD);
  assign pix_end     = (ph_q == PH_B);
  assign line_end    = pix_end && (h_q == h_tot - H_W'(1));
  assign field_end   = line_end && (v_q == v_len - V_W'(1));

  always_ff @(negedge nCLK) begin
    if (RST) begin
      ph_q <= PH_SYNC;
    end else begin
      ph_q <= ph_d;
    end
  end

  always_comb begin
    ph_d = PH_SYNC;
    case (ph_q)
      PH_SYNC: ph_d = PH_R;
      PH_R:    ph_d = PH_G;
      PH_G:    ph_d = PH_B;
      default: ph_d = PH_SYNC;
    endcase
  end

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    field_d = field_q;
    if (pix_end) begin
      h_d = line_end ? '0 : h_q + H_W'(1);
      if (line_end) begin
        v_d = field_end ? '0 : v_q + V_W'(1);
        if (field_end) begin
          field_d = (i480_q && field_q == FIELD_ODD) ? FIELD_EVEN : FIELD_ODD;
        end
      end
    end
  end

  // Mode inputs only take effect at the start of an odd field, so a frame is never split.
  always_ff @(negedge nCLK) begin
    if (RST) begin
      h_q     <= '0;
      v_q     <= '0;
      field_q <= FIELD_ODD;
      vmode_q <= vmode_i;
      i480_q  <= n64_480i_i;
      pat_q   <= pattern_e'(pattern_i);
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      field_q <= field_d;
      if (frame_bound) begin
        vmode_q <= vmode_i;
        i480_q  <= n64_480i_i;
      end
      if (line_start) begin
        pat_q <= pattern_e'(pattern_i);
      end
    end
  end

  // Even-field vsync spans half-line to half-line; clamp is suppressed wherever nVSYNC is low.
  always_comb begin
    nhs = (h_q >= HSYNC_END);
    if (field_q == FIELD_ODD) begin
      nvs = (v_q >= VSYNC_END);
    end else begin
      nvs = !((v_q != '0 || h_q >= h_half) &&
              (v_q < VSYNC_END || (v_q == VSYNC_END && h_q < h_half)));
    end
    ncl = !(nvs && h_q >= CLAMP_BEG && h_q < CLAMP_END);
    ncs = nvs ? nhs : !nhs;
  end

  assign vact_end = vmode_q ? VACT_END_P : VACT_END_N;
  assign active   = (h_q >= HACT_BEG) && (h_q < HACT_END) &&
                    (v_q >= VACT_BEG) && (v_q < vact_end);
  assign ha       = h_q - HACT_BEG;
  assign va       = v_q - VACT_BEG;

  n64_vgen_pattern u_pattern (
    .clk_i     (nCLK),
    .rst_i     (RST),
    .load_i    (ph_q == PH_SYNC),
    .active_i  (active),
    .pattern_i (pat_q),
    .ha_i      (ha),
    .va_i      (va),
    .rgb_o     (rgb)
  );

  always_comb begin
    nds_d = 1'b1;
    d_d   = '0;
    fs_d  = 1'b0;
    case (ph_q)
      PH_SYNC: begin
        nds_d           = 1'b0;
        d_d[NIB_VSYNC]  = nvs;
        d_d[NIB_CLAMP]  = ncl;
        d_d[NIB_HSYNC]  = nhs;
        d_d[NIB_CSYNC]  = ncs;
        fs_d            = frame_bound;
      end
      PH_R:    d_d = rgb.r;
      PH_G:    d_d = rgb.g;
      default: d_d = rgb.b;
    endcase
  end

  always_ff @(negedge nCLK) begin
    if (RST) begin
      nds_q <= 1'b1;
      d_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      nds_q <= nds_d;
      d_q   <= d_d;
      fs_q  <= fs_d;
    end
  end

  assign nDSYNC        = nds_q;
  assign D_o           = d_q;
  assign frame_start_o = fs_q;

endmodule
